// File: rtl/fifo_reader.sv
// Round-robin reader for four 1-cycle-latency upstream FIFOs, feeding a
// 2-entry ordered output buffer with a valid/ready handshake and word counter.
module fifo_reader #(
  parameter int DATA_W = 6
) (
  input  logic                  clk,
  input  logic                  RESET_L,
  input  logic [3:0]            fifo_empty_in,
  input  logic [4*DATA_W-1:0]   fifo_data_in,
  output logic [3:0]            fifo_rd,
  input  logic                  pause,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [1:0]            out_ch,
  output logic [7:0]            word_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0][DATA_W-1:0]  buf_data_q, buf_data_d;
  logic [1:0][1:0]         buf_ch_q, buf_ch_d;
  logic [1:0]              cnt_q, cnt_d;
  logic                    infl_q, infl_d;
  logic [1:0]              infl_ch_q, infl_ch_d;
  logic [1:0]              last_q, last_d;
  logic [7:0]              word_cnt_q, word_cnt_d;

  logic                    deq_s;
  logic [2:0]              occ_s;
  logic                    credit_ok_s;
  logic                    all_empty_s;
  logic                    grant_vld_s;
  logic [1:0]              grant_ch_s;
  logic [1:0]              cand_s;
  logic                    pop_s;
  logic [DATA_W-1:0]       cap_data_s;
  logic [1:0]              fill_s;

  assign deq_s       = (cnt_q != 2'd0) && out_ready;
  assign occ_s       = {1'b0, cnt_q} + {2'b00, infl_q};
  // Room is judged after this cycle's dequeue, so a full buffer can stream.
  assign credit_ok_s = (occ_s - {2'b00, deq_s}) < 3'd2;
  assign all_empty_s = &fifo_empty_in;
  assign cap_data_s  = fifo_data_in[DATA_W*infl_ch_q +: DATA_W];

  // Round-robin search starting after the last granted channel
  always_comb begin
    grant_vld_s = 1'b0;
    grant_ch_s  = last_q;
    cand_s      = last_q;
    for (int k = 1; k <= 4; k++) begin
      cand_s = last_q + 2'(k);
      if (!grant_vld_s && !fifo_empty_in[cand_s]) begin
        grant_vld_s = 1'b1;
        grant_ch_s  = cand_s;
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  assign pop_s   = RESET_L && (state_q == S_RUN) && !pause && credit_ok_s && grant_vld_s;
  assign fifo_rd = pop_s ? (4'b0001 << grant_ch_s) : 4'b0000;

  // Buffer, in-flight tracking, pointer and counter next state
  always_comb begin
    buf_data_d = buf_data_q;
    buf_ch_d   = buf_ch_q;
    fill_s     = cnt_q;
    if (deq_s) begin
      buf_data_d[0] = buf_data_q[1];
      buf_ch_d[0]   = buf_ch_q[1];
      fill_s        = cnt_q - 2'd1;
    end else begin
      fill_s        = cnt_q;
    end
    if (infl_q) begin
      buf_data_d[fill_s[0]] = cap_data_s;
      buf_ch_d[fill_s[0]]   = infl_ch_q;
      fill_s                = fill_s + 2'd1;
    end else begin
      fill_s                = fill_s;
    end
    cnt_d      = fill_s;
    infl_d     = pop_s;
    infl_ch_d  = grant_ch_s;
    last_d     = pop_s ? grant_ch_s : last_q;
    word_cnt_d = word_cnt_q + (deq_s ? 8'd1 : 8'd0);
  end

  // Control FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pause)             state_d = S_PAUSED;
        else if (!all_empty_s) state_d = S_RUN;
        else                   state_d = S_IDLE;
      end
      S_RUN: begin
        if (pause)            state_d = S_PAUSED;
        else if (all_empty_s) state_d = S_IDLE;
        else                  state_d = S_RUN;
      end
      S_PAUSED: begin
        if (pause)            state_d = S_PAUSED;
        else if (all_empty_s) state_d = S_IDLE;
        else                  state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!RESET_L) begin
      state_q    <= S_IDLE;
      buf_data_q <= '0;
      buf_ch_q   <= '0;
      cnt_q      <= 2'd0;
      infl_q     <= 1'b0;
      infl_ch_q  <= 2'd0;
      last_q     <= 2'd3;
      word_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      buf_data_q <= buf_data_d;
      buf_ch_q   <= buf_ch_d;
      cnt_q      <= cnt_d;
      infl_q     <= infl_d;
      infl_ch_q  <= infl_ch_d;
      last_q     <= last_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = buf_data_q[0];
  assign out_ch    = buf_ch_q[0];
  assign word_cnt  = word_cnt_q;

endmodule
